// File: rtl/branch_pht_if.sv
// rtl/branch_pht_if.sv - lookup/update/flush bundle between fetch/execute and the pattern history table
interface branch_pht_if #(
    parameter int INDEX_BITS = 6,
    parameter int GHR_BITS   = 6,
    parameter int PC_WIDTH   = 32
);
    logic                  lookup_valid;
    logic [PC_WIDTH-1:0]   lookup_pc;
    logic                  pred_valid;
    logic                  pred_taken;
    logic [INDEX_BITS-1:0] pred_index;
    logic                  upd_valid;
    logic [INDEX_BITS-1:0] upd_index;
    logic                  upd_taken;
    logic                  flush;
    logic [GHR_BITS-1:0]   ghr;

    modport master (
        output lookup_valid, lookup_pc, upd_valid, upd_index, upd_taken, flush,
        input  pred_valid, pred_taken, pred_index, ghr
    );

    modport slave (
        input  lookup_valid, lookup_pc, upd_valid, upd_index, upd_taken, flush,
        output pred_valid, pred_taken, pred_index, ghr
    );
endinterface

// File: rtl/branch_pht.sv
// rtl/branch_pht.sv - 2-bit counter branch direction table, bimodal or gshare (GSHARE_EN)
module branch_pht #(
    parameter int INDEX_BITS = 6,
    parameter int GHR_BITS   = 6,
    parameter int PC_WIDTH   = 32
) (
    input  logic         clk,
    input  logic         reset,
    branch_pht_if.slave  bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            ctr [ENTRIES];
    logic [INDEX_BITS-1:0] lookup_index;
    logic [1:0]            upd_cur;
    logic [1:0]            upd_next;
    logic                  pred_valid_q;
    logic                  pred_taken_q;
    logic [INDEX_BITS-1:0] pred_index_q;

`ifdef GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
        end else if (bus.upd_valid) begin
            ghr_q <= GHR_BITS'({ghr_q, bus.upd_taken});
        end
    end

    assign lookup_index = bus.lookup_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
    assign bus.ghr      = ghr_q;
`else
    assign lookup_index = bus.lookup_pc[INDEX_BITS+1:2];
    assign bus.ghr      = '0;
`endif

    always_comb begin
        upd_cur  = ctr[bus.upd_index];
        upd_next = upd_cur;
        if (bus.upd_taken) begin
            if (upd_cur != 2'b11) upd_next = upd_cur + 2'b01;
        end else begin
            if (upd_cur != 2'b00) upd_next = upd_cur - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= 2'b01;
            end
        end else if (bus.upd_valid) begin
            ctr[bus.upd_index] <= upd_next;
        end
    end

    // Lookup reads the pre-edge table, so a same-cycle update is not bypassed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_index_q <= '0;
        end else begin
            pred_valid_q <= bus.lookup_valid & ~bus.flush;
            if (bus.lookup_valid && !bus.flush) begin
                pred_taken_q <= ctr[lookup_index][1];
                pred_index_q <= lookup_index;
            end
        end
    end

    assign bus.pred_valid = pred_valid_q;
    assign bus.pred_taken = pred_taken_q;
    assign bus.pred_index = pred_index_q;
endmodule

// File: doc/branch_pht.md
BRANCH_PHT -- requirements
Module: branch_pht

Interface
REQ-001 Parameter: INDEX_BITS, default 6, log2 of table entries (64).
REQ-002 Parameter: GHR_BITS, default 6, global history length; SHALL be <= INDEX_BITS.
REQ-003 Parameter: PC_WIDTH, default 32, fetch PC width.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 lookup_valid  in  1  fetch requests a prediction this cycle.
REQ-007 lookup_pc  in  PC_WIDTH  fetch PC of the branch being predicted.
REQ-008 pred_valid  out  1  registered; prediction outputs valid.
REQ-009 pred_taken  out  1  registered; 1 = predict taken.
REQ-010 pred_index  out  INDEX_BITS  registered; table index used, carried down the pipe for update.
REQ-011 upd_valid  in  1  execute reports a resolved conditional branch.
REQ-012 upd_index  in  INDEX_BITS  index returned from pred_index.
REQ-013 upd_taken  in  1  resolved direction, 1 = taken.
REQ-014 flush  in  1  pipeline flush; kills an in-flight prediction.
REQ-015 ghr  out  GHR_BITS  current global history register, debug and verification visibility.

Function
REQ-016 Table: 2^INDEX_BITS entries of 2-bit saturating counters, encoding SNT=00, WNT=01, WT=10, ST=11.
REQ-017 Index = lookup_pc[INDEX_BITS+1:2] XOR {zero-extended ghr} (with GSHARE_EN); counter MSB gives direction.
REQ-018 Latency 1: lookup_valid at edge N -> pred_valid/pred_taken/pred_index valid after edge N+1.
REQ-019 pred_valid SHALL be 1 for exactly one cycle per accepted lookup; lookup_valid=0 -> pred_valid=0 next cycle.
REQ-020 flush=1 SHALL force pred_valid=0 next cycle, overriding a same-cycle lookup_valid; pred_taken/pred_index hold.
REQ-021 Update, upd_valid=1: counter[upd_index] moves +1 if taken, -1 if not taken, saturating at 11 and 00.
REQ-022 Update SHALL shift ghr left by one, inserting upd_taken at bit 0; oldest bit discarded.
REQ-023 upd_valid=0: table and ghr unchanged.
REQ-024 Same-cycle lookup and update, any index: lookup SHALL use table contents and ghr from before that edge (no bypass); update takes effect for lookups at the next cycle.
REQ-025 flush SHALL NOT affect table, ghr, or a same-cycle update.
REQ-026 No table arbitration stall: one lookup and one update accepted every cycle.

Reset
REQ-027 reset low SHALL immediately, independent of clk, set all counters to WNT (01), ghr to 0, pred_valid 0, pred_taken 0, pred_index 0.
REQ-028 Reset mid-operation SHALL discard the in-flight prediction and all training; first lookup after reset release predicts not-taken.
REQ-029 Lookup/update inputs in the cycle reset deasserts SHALL be accepted normally on the first rising edge with reset high.

Configuration
REQ-030 Macro GSHARE_EN: defined -> gshare indexing per REQ-017 and ghr updated per REQ-022.
REQ-031 GSHARE_EN undefined -> bimodal: index = lookup_pc[INDEX_BITS+1:2], ghr register absent, ghr output tied to 0; all other behaviour identical.

Verification
REQ-032 Reset, lookup pc=0x40 -> next cycle pred_valid=1, pred_taken=0, pred_index=0x10.
REQ-033 GSHARE_EN: two updates upd_index=0x10 taken -> ghr=0x03; lookup pc=0x4C -> pred_index=0x10, pred_taken=1 (counter=ST).
REQ-034 Index 0x05: three taken updates -> 11; one not-taken -> 10, lookup predicts taken; second not-taken -> 01, predicts not-taken; six not-taken from 00 stays 00.
REQ-035 From reset, same cycle lookup pc=0x00 and update index 0x00 taken -> pred_taken=0; bimodal re-lookup pc=0x00 next cycle -> pred_taken=1.
REQ-036 Lookup_valid=1 with flush=1 -> pred_valid=0 next cycle; after training, reset pulse low mid-cycle -> pred_valid=0 and ghr=0 before next edge, pc=0x40 lookup predicts 0.
REQ-037 Build without GSHARE_EN: ghr constantly 0 after taken updates; lookup pc=0x4C -> pred_index=0x13.
